// File: rtl/vend_controller.sv
// vend_controller: selects a product through the price mux, collects coins, then dispenses or refunds
module vend_controller #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    input  logic       cancel,
    input  logic       change_ack,
    input  logic [7:0] price_in,
    output logic [3:0] mux_sel,
    output logic [7:0] credit,
    output logic       dispense,
    output logic [1:0] dispense_item,
    output logic       change_valid,
    output logic [7:0] change_amount,
    output logic       coin_reject,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
    state_t      state, state_n;
    logic [1:0]  item, item_n;
    logic [15:0] tcnt, tcnt_n;
    logic [3:0]  mux_sel_n;
    logic [7:0]  credit_n, change_amount_n, refund;
    logic        dispense_n, change_valid_n, coin_reject_n;
    logic [1:0]  dispense_item_n;
    logic [8:0]  sum;
    logic [7:0]  sat;
    logic        timeout;
    assign sum     = {1'b0, credit} + {1'b0, coin_value};
    assign sat     = sum[8] ? 8'hff : sum[7:0];
    assign timeout = tcnt == 16'(TIMEOUT_CYC - 1);
    assign refund  = (credit >= price_in) ? credit - price_in : 8'd0;
    always_comb begin
        state_n         = state;
        item_n          = item;
        tcnt_n          = tcnt;
        mux_sel_n       = mux_sel;
        credit_n        = credit;
        change_amount_n = change_amount;
        change_valid_n  = change_valid;
        dispense_n      = 1'b0;
        dispense_item_n = 2'd0;
        coin_reject_n   = 1'b0;
        case (state)
            IDLE: begin
                mux_sel_n       = 4'd0;
                credit_n        = 8'd0;
                tcnt_n          = 16'd0;
                change_valid_n  = 1'b0;
                change_amount_n = 8'd0;
                coin_reject_n   = coin_valid;
                if (sel != 4'd0) begin
                    item_n    = sel[0] ? 2'd0 : sel[1] ? 2'd1 : sel[2] ? 2'd2 : 2'd3;
                    mux_sel_n = 4'b0001 << item_n;
                    state_n   = COLLECT;
                end
            end
            COLLECT: begin
                credit_n = coin_valid ? sat : credit;
                tcnt_n   = coin_valid ? 16'd0 : tcnt + 16'd1;
                // refund includes a coin arriving in the same cycle as the cancel
                if (cancel || timeout) begin
                    change_amount_n = credit_n;
                    if (credit_n != 8'd0) begin
                        state_n        = CHANGE;
                        change_valid_n = 1'b1;
                    end else begin
                        state_n   = IDLE;
                        mux_sel_n = 4'd0;
                        tcnt_n    = 16'd0;
                    end
                end else if (credit >= price_in) begin
                    state_n         = DISPENSE;
                    dispense_n      = 1'b1;
                    dispense_item_n = item;
                end
            end
            DISPENSE: begin
                coin_reject_n   = coin_valid;
                change_amount_n = refund;
                if (refund != 8'd0) begin
                    state_n        = CHANGE;
                    change_valid_n = 1'b1;
                end else begin
                    state_n   = IDLE;
                    credit_n  = 8'd0;
                    mux_sel_n = 4'd0;
                    tcnt_n    = 16'd0;
                end
            end
            CHANGE: begin
                coin_reject_n = coin_valid;
                if (change_ack) begin
                    state_n         = IDLE;
                    change_valid_n  = 1'b0;
                    change_amount_n = 8'd0;
                    credit_n        = 8'd0;
                    mux_sel_n       = 4'd0;
                    tcnt_n          = 16'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            item          <= 2'd0;
            tcnt          <= 16'd0;
            mux_sel       <= 4'd0;
            credit        <= 8'd0;
            dispense      <= 1'b0;
            dispense_item <= 2'd0;
            change_valid  <= 1'b0;
            change_amount <= 8'd0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            item          <= item_n;
            tcnt          <= tcnt_n;
            mux_sel       <= mux_sel_n;
            credit        <= credit_n;
            dispense      <= dispense_n;
            dispense_item <= dispense_item_n;
            change_valid  <= change_valid_n;
            change_amount <= change_amount_n;
            coin_reject   <= coin_reject_n;
            busy          <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed stimulus with a queue scoreboard for dispense, change and reject events
module tb_vend_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sel = 4'd0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = 8'd0;
    logic       cancel = 1'b0;
    logic       change_ack = 1'b0;
    logic [7:0] price_in;
    logic [3:0] mux_sel;
    logic [7:0] credit;
    logic       dispense;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic       busy;

    logic [7:0] prices [4];
    typedef struct {int kind; int val; int at;} exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int c;
    logic cv_prev = 1'b0;

    vend_controller #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .sel(sel), .coin_valid(coin_valid), .coin_value(coin_value),
        .cancel(cancel), .change_ack(change_ack), .price_in(price_in), .mux_sel(mux_sel),
        .credit(credit), .dispense(dispense), .dispense_item(dispense_item),
        .change_valid(change_valid), .change_amount(change_amount),
        .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign price_in = mux_sel[0] ? prices[0] : mux_sel[1] ? prices[1] :
                      mux_sel[2] ? prices[2] : mux_sel[3] ? prices[3] : 8'd0;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 dispense (val=item), 1 change (val=amount), 2 coin reject
    task automatic sb(int kind, int val);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, expected no event", kind, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val != val || (e.at >= 0 && e.at != cyc)) begin
                miscompares++;
                $display("FAIL scoreboard: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.at);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (dispense) sb(0, int'(dispense_item));
            if (change_valid && !cv_prev) sb(1, int'(change_amount));
            if (coin_reject) sb(2, 0);
        end
        cv_prev = change_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(logic [3:0] s);
        sel = s;
        tick();
        sel = 4'd0;
    endtask

    task automatic coin(int v);
        coin_valid = 1'b1;
        coin_value = 8'(v);
        tick();
        coin_valid = 1'b0;
        c = cyc;
    endtask

    task automatic ack();
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_mux_sel"}, int'(mux_sel), 0);
        chk({tag, "_credit"}, int'(credit), 0);
        chk({tag, "_dispense"}, int'(dispense), 0);
        chk({tag, "_dispense_item"}, int'(dispense_item), 0);
        chk({tag, "_change_valid"}, int'(change_valid), 0);
        chk({tag, "_change_amount"}, int'(change_amount), 0);
        chk({tag, "_coin_reject"}, int'(coin_reject), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        prices[0] = 8'd100;
        prices[1] = 8'd50;
        prices[2] = 8'd255;
        prices[3] = 8'd30;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("reset");

        // exact payment
        pick(4'b0110);
        chk("exact_mux_sel", int'(mux_sel), 2);
        chk("exact_busy", int'(busy), 1);
        coin(20);
        coin(20);
        coin(10);
        q.push_back('{0, 1, c + 1});
        repeat (3) tick();
        chk("exact_credit", int'(credit), 0);
        chk("exact_busy_after", int'(busy), 0);
        chk("exact_mux_after", int'(mux_sel), 0);

        // overpayment with delayed ack
        pick(4'b1000);
        chk("over_mux_sel", int'(mux_sel), 8);
        coin(50);
        q.push_back('{0, 3, c + 1});
        q.push_back('{1, 20, c + 2});
        repeat (6) tick();
        chk("over_change_valid_held", int'(change_valid), 1);
        chk("over_change_amount", int'(change_amount), 20);
        ack();
        chk("over_change_valid_cleared", int'(change_valid), 0);
        chk("over_credit_cleared", int'(credit), 0);

        // cancel after a coin
        pick(4'b0001);
        coin(20);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        q.push_back('{1, 20, cyc});
        ack();
        chk("cancel_busy", int'(busy), 0);

        // coin and cancel together
        pick(4'b0001);
        coin(10);
        coin_valid = 1'b1;
        coin_value = 8'd15;
        cancel = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel = 1'b0;
        q.push_back('{1, 25, cyc});
        chk("coin_cancel_amount", int'(change_amount), 25);
        ack();

        // timeout
        pick(4'b0001);
        coin(5);
        q.push_back('{1, 5, c + 8});
        repeat (7) tick();
        chk("timeout_not_yet", int'(change_valid), 0);
        tick();
        chk("timeout_valid", int'(change_valid), 1);
        chk("timeout_amount", int'(change_amount), 5);
        ack();

        // saturating credit at price 255
        pick(4'b0100);
        coin(200);
        coin(100);
        q.push_back('{0, 2, c + 1});
        chk("sat_credit", int'(credit), 255);
        repeat (3) tick();
        chk("sat_credit_cleared", int'(credit), 0);

        // coin while idle
        coin_valid = 1'b1;
        coin_value = 8'd7;
        tick();
        coin_valid = 1'b0;
        q.push_back('{2, 0, cyc});
        chk("idle_coin_reject", int'(coin_reject), 1);
        chk("idle_coin_credit", int'(credit), 0);
        tick();

        // reset while in CHANGE
        pick(4'b0001);
        coin(30);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        q.push_back('{1, 30, cyc});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rst_change");

        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the vending machine's 4-way price multiplexer. It captures a product request from four select buttons, drives the mux one-hot selects, and reads back the selected price. It then accumulates inserted coins against that price and issues either a dispense pulse plus change, or a full refund on cancel or timeout. It sits between the button/coin front end and the dispense/change actuators.

## Interface
Parameters:
- TIMEOUT_CYC, 1000: COLLECT cycles without a coin before an automatic cancel (range 2..65535).

Ports:
- clk  input  1  system clock; everything is rising-edge.
- rst  input  1  synchronous reset, active-high.
- sel  input  4  product buttons; sel[0] has highest priority, sel[3] lowest.
- coin_valid  input  1  one-cycle strobe: a coin is present.
- coin_value  input  8  value of the coin, qualified by coin_valid.
- cancel  input  1  user cancel, level-sampled.
- change_ack  input  1  change payer has taken change_amount.
- price_in  input  8  price returned by the price mux for mux_sel.
- mux_sel  output  4  one-hot select bits to the price mux (select0..select3 = bits 0..3).
- credit  output  8  accumulated credit.
- dispense  output  1  one-cycle pulse: release the item.
- dispense_item  output  2  index of the item, valid while dispense is high.
- change_valid  output  1  change_amount is valid; held until change_ack.
- change_amount  output  8  amount to return.
- coin_reject  output  1  one-cycle pulse: a coin was refused.
- busy  output  1  high in any state other than IDLE.

## Operation
- All outputs are registered. Reset values: state IDLE, mux_sel=0, credit=0, dispense=0, dispense_item=0, change_valid=0, change_amount=0, coin_reject=0, busy=0, timeout counter=0.
- There are four states: IDLE, COLLECT, DISPENSE, CHANGE.
- **IDLE**
  - mux_sel=0 and credit=0.
  - If sel≠0: latch the one-hot of the lowest set bit into mux_sel and its index into an item register, then go to COLLECT.
  - coin_valid in IDLE: coin_reject pulses the next cycle and credit is unchanged.
- **COLLECT**
  - mux_sel is held. Any change on sel is ignored.
  - coin_valid: credit <= min(credit+coin_value, 255), computed 9-bit then saturated. The timeout counter clears.
  - Otherwise the timeout counter increments.
  - Decision each cycle uses the registered credit, with this priority:
    1. cancel, or timeout counter == TIMEOUT_CYC-1: change_amount <= credit of the next cycle (including any coin accepted this cycle), then go to CHANGE if that value is nonzero, else to IDLE.
    2. credit >= price_in: go to DISPENSE.
- **DISPENSE**
  - Lasts exactly one cycle: dispense=1 and dispense_item=item.
  - change_amount <= credit - price_in (never negative).
  - Next state is CHANGE if change_amount is nonzero, else IDLE.
  - Coins are rejected.
- **CHANGE**
  - change_valid=1 and change_amount is held stable.
  - On change_ack: change_valid <= 0, credit <= 0, mux_sel <= 0, then go to IDLE.
  - Coins are rejected.
- Leaving to IDLE always clears credit, mux_sel and the timeout counter.
- Reset in any state aborts immediately: no dispense, and credit is discarded.

## Timing
- sel sampled at edge N: mux_sel is valid from N+1. price_in is compared from N+1 onward; the mux is combinational.
- Coin accepted at edge N: credit updates at N+1. If credit >= price_in, dispense is high during cycle N+2 and change_valid rises at N+3.
- Cancel sampled at edge N: change_valid is high from N+1.
- A timeout fires TIMEOUT_CYC cycles after COLLECT entry or after the last coin.
- change_ack held high: CHANGE lasts one cycle, and IDLE accepts a new sel on the following edge.
- coin_reject follows the rejected coin_valid by one cycle.

## Test plan
- **Exact payment.** price_in=50, sel=4'b0110.
  - Required: mux_sel=4'b0010 and busy=1.
  - Then coins 20, 20, 10 -> dispense pulse with dispense_item=1, no change_valid, back to IDLE with credit=0.
- **Overpayment.** price 30, sel=4'b1000, coin 50.
  - Required: dispense_item=3, change_amount=20.
  - change_valid holds for 5 cycles until change_ack.
- **Cancel after a coin.** Coin 20, then cancel.
  - Required: no dispense, change_amount=20.
- **Coin and cancel in the same cycle.** credit=10, coin 15 together with cancel.
  - Required: change_amount=25.
- **Timeout.** TIMEOUT_CYC=8, coin 5, then idle.
  - Required: change_amount=5 exactly 8 cycles after the coin.
- **Corner cases:**
  - Price 255; coins 200 then 100 -> credit=255, dispense, no change.
  - Coin in IDLE -> coin_reject=1 and credit=0.
  - rst asserted in CHANGE -> every output back to its reset value next cycle.
